dog_extrema_detect: RTL and testbench
=====================================

// Module: dog_extrema_detect
// PURPOSE
//  Consumer of the 3x3x3 DoG neighbourhood stream from the 27-point window builder. For each
//  window it tests whether the centre sample (scale 2, position 5) is a strict local max or min
//  versus its 26 neighbours and passes a contrast threshold. Qualifying points are tagged with
//  pixel coordinates and queued in a small FIFO (valid/ready) for the descriptor stage.
// PARAMETERS
//  DW          8    sample width, two's-complement signed DoG value
//  IMG_W       640  pixels per row (window centres per row)
//  IMG_H       480  rows per frame
//  XW          10   kp_x width; must satisfy 2**XW >= IMG_W
//  YW          9    kp_y width; must satisfy 2**YW >= IMG_H
//  CONTRAST_TH 3    minimum |centre| for acceptance (unsigned, < 2**(DW-1))
//  FIFO_DEPTH  16   keypoint FIFO entries, power of 2, >= 2
// PORTS
//  clk         in   1       rising-edge clock
//  rst         in   1       asynchronous reset, active-high
//  win_en      in   1       window valid; connect to window builder out_en
//  win         in   27*DW   flattened window; slice k=(s-1)*9+(p-1), scale s=1..3, pos p=1..9 row-major; centre k=13
//  kp_valid    out  1       FIFO head valid
//  kp_ready    in   1       downstream accepts head
//  kp_x        out  XW      keypoint column
//  kp_y        out  YW      keypoint row
//  kp_max      out  1       1 = maximum, 0 = minimum
//  kp_val      out  DW      centre DoG value
//  kp_ovf      out  1       sticky: a keypoint was dropped because the FIFO was full
//  frame_done  out  1       one-cycle pulse when the last window of a frame leaves stage 3
// BEHAVIOUR
//  - Reset: all outputs 0; FIFO empty; pipeline valids cleared; col/row counters 0.
//    rst mid-frame discards in-flight windows and queued keypoints; the next win_en is (0,0).
//  - Coordinates: col/row count win_en pulses. The pulse carrying window n has centre
//    (n mod IMG_W, n div IMG_W). col wraps at IMG_W-1 -> 0 with row+1. At (IMG_W-1, IMG_H-1),
//    both counters wrap to 0. Coordinates travel down the pipeline with the window.
//  - Stage 1 (cycle +1): 26 signed compares. gt[i] = c > n_i, lt[i] = c < n_i.
//    Ties fail both tests.
//  - Stage 2 (+2): is_max = &gt, is_min = &lt; |c| is computed in DW+1 bits, so -128 gives 128.
//  - Stage 3 (+3): accept = (is_max | is_min) & (|c| >= CONTRAST_TH) & not border.
//    Border = col 0, col IMG_W-1, row 0 or row IMG_H-1.
//    Accepted entries are pushed {x, y, is_max, c}.
//  - Timing: push occurs 3 cycles after the win_en sample. The pipeline never stalls;
//    win_en may be high on every cycle.
//  - FIFO handshake: an entry pops when kp_valid & kp_ready.
//    kp_* outputs are driven from the head, first-word fall-through; a push into an empty
//    FIFO gives kp_valid on the next cycle. kp_x/y/max/val are stable while kp_valid & !kp_ready.
//  - Full FIFO: a push with a same-cycle pop is accepted and the count is unchanged.
//    A push without a pop is dropped and kp_ovf sets to 1; kp_ovf clears only on rst.
//  - Empty FIFO: kp_valid=0 and kp_* hold their last values. kp_ready is ignored.
//  - frame_done asserts with the stage-3 result of window (IMG_W-1, IMG_H-1), whether or not
//    that window is accepted.
// CONFIGURATION
//  `EXTREMA_DROP_CNT_EN defined: adds output port drop_cnt [15:0]. It counts dropped keypoints,
//    saturates at 16'hFFFF and resets to 0 on rst.
//  Not defined: the port and the counter are absent; kp_ovf is the only overflow indication.
// TESTING
//  1. IMG_W=8, IMG_H=6; window at (3,2) has centre 50 and all neighbours 10; kp_ready=1.
//     -> Exactly one keypoint: x=3, y=2, max=1, val=50, with kp_valid 4 cycles after win_en.
//  2. Same setup, centre -40 and neighbours 0.
//     -> min keypoint, val=-40.
//     Same setup, one neighbour set equal to the centre.
//     -> no keypoint.
//  3. CONTRAST_TH=3; centre 2 (max) -> rejected. Centre 3 -> accepted. Centre -128 with neighbours 0 -> accepted.
//  4. Strict extremum placed at (0,2), (7,2), (3,0) and (3,5) -> no keypoints.
//     A 48-window frame ends -> one frame_done pulse, and the next window maps to (0,0).
//  5. FIFO_DEPTH=4, kp_ready=0, 6 accepted windows -> 4 queued, kp_ovf=1, drop_cnt=2 (when the macro is enabled).
//     Then release kp_ready -> 4 entries pop in push order.
//     Also check: full FIFO, push and pop in the same cycle -> no drop.
//  6. rst pulsed while 3 windows are in flight and 2 entries are queued
//     -> kp_valid=0 next cycle, kp_ovf=0, no stale keypoints ever emitted.

Source files
------------

// File: rtl/dog_extrema_detect.sv
// Flags strict 3x3x3 DoG extrema that pass a contrast threshold and queues them with pixel coordinates.
// Optional build macro EXTREMA_DROP_CNT_EN adds a saturating dropped-keypoint counter on port drop_cnt.
module dog_extrema_detect #(
    parameter int DW          = 8,
    parameter int IMG_W       = 640,
    parameter int IMG_H       = 480,
    parameter int XW          = 10,
    parameter int YW          = 9,
    parameter int CONTRAST_TH = 3,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             win_en,
    input  logic [27*DW-1:0] win,
    output logic             kp_valid,
    input  logic             kp_ready,
    output logic [XW-1:0]    kp_x,
    output logic [YW-1:0]    kp_y,
    output logic             kp_max,
    output logic [DW-1:0]    kp_val,
    output logic             kp_ovf,
    output logic             frame_done
`ifdef EXTREMA_DROP_CNT_EN
    ,
    output logic [15:0]      drop_cnt
`endif
);

    localparam int NN = 26;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = XW + YW + 1 + DW;
    localparam logic [XW-1:0] L_COL_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] L_ROW_LAST = YW'(IMG_H - 1);
    localparam logic [DW:0]   L_TH       = (DW+1)'(CONTRAST_TH);

    // ---------------- window coordinate counters ----------------
    logic [XW-1:0] r_col;
    logic [YW-1:0] r_row;
    logic          w_col_last;
    logic          w_row_last;
    logic          w_border;
    logic          w_last;

    assign w_col_last = (r_col == L_COL_LAST);
    assign w_row_last = (r_row == L_ROW_LAST);
    assign w_border   = (r_col == '0) | w_col_last | (r_row == '0) | w_row_last;
    assign w_last     = w_col_last & w_row_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (win_en) begin
            if (w_col_last) begin
                r_col <= '0;
                r_row <= w_row_last ? '0 : r_row + YW'(1);
            end else begin
                r_col <= r_col + XW'(1);
            end
        end
    end

    // ---------------- stage 1: centre vs 26 neighbours ----------------
    logic signed [DW-1:0] w_c;
    logic [NN-1:0]        w_gt;
    logic [NN-1:0]        w_lt;

    assign w_c = $signed(win[13*DW +: DW]);

    for (genvar j = 0; j < NN; j++) begin : g_cmp
        localparam int K = (j < 13) ? j : j + 1;
        assign w_gt[j] = w_c > $signed(win[K*DW +: DW]);
        assign w_lt[j] = w_c < $signed(win[K*DW +: DW]);
    end

    logic                 r_s1_vld;
    logic [NN-1:0]        r_s1_gt;
    logic [NN-1:0]        r_s1_lt;
    logic signed [DW-1:0] r_s1_c;
    logic [XW-1:0]        r_s1_x;
    logic [YW-1:0]        r_s1_y;
    logic                 r_s1_border;
    logic                 r_s1_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld    <= 1'b0;
            r_s1_gt     <= '0;
            r_s1_lt     <= '0;
            r_s1_c      <= '0;
            r_s1_x      <= '0;
            r_s1_y      <= '0;
            r_s1_border <= 1'b0;
            r_s1_last   <= 1'b0;
        end else begin
            r_s1_vld    <= win_en;
            r_s1_gt     <= w_gt;
            r_s1_lt     <= w_lt;
            r_s1_c      <= w_c;
            r_s1_x      <= r_col;
            r_s1_y      <= r_row;
            r_s1_border <= w_border;
            r_s1_last   <= w_last;
        end
    end

    // ---------------- stage 2: extremum reduction and magnitude ----------------
    // Magnitude is one bit wider so the most negative sample maps to a positive value.
    logic [DW:0] w_c_ext;
    logic [DW:0] w_abs;

    assign w_c_ext = {r_s1_c[DW-1], r_s1_c};
    assign w_abs   = r_s1_c[DW-1] ? (~w_c_ext + (DW+1)'(1)) : w_c_ext;

    logic                 r_s2_vld;
    logic                 r_s2_max;
    logic                 r_s2_min;
    logic [DW:0]          r_s2_abs;
    logic signed [DW-1:0] r_s2_c;
    logic [XW-1:0]        r_s2_x;
    logic [YW-1:0]        r_s2_y;
    logic                 r_s2_border;
    logic                 r_s2_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld    <= 1'b0;
            r_s2_max    <= 1'b0;
            r_s2_min    <= 1'b0;
            r_s2_abs    <= '0;
            r_s2_c      <= '0;
            r_s2_x      <= '0;
            r_s2_y      <= '0;
            r_s2_border <= 1'b0;
            r_s2_last   <= 1'b0;
        end else begin
            r_s2_vld    <= r_s1_vld;
            r_s2_max    <= &r_s1_gt;
            r_s2_min    <= &r_s1_lt;
            r_s2_abs    <= w_abs;
            r_s2_c      <= r_s1_c;
            r_s2_x      <= r_s1_x;
            r_s2_y      <= r_s1_y;
            r_s2_border <= r_s1_border;
            r_s2_last   <= r_s1_last;
        end
    end

    // ---------------- stage 3: acceptance ----------------
    logic                 r_s3_vld;
    logic                 r_s3_acc;
    logic                 r_s3_max;
    logic signed [DW-1:0] r_s3_c;
    logic [XW-1:0]        r_s3_x;
    logic [YW-1:0]        r_s3_y;
    logic                 r_s3_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s3_vld  <= 1'b0;
            r_s3_acc  <= 1'b0;
            r_s3_max  <= 1'b0;
            r_s3_c    <= '0;
            r_s3_x    <= '0;
            r_s3_y    <= '0;
            r_s3_last <= 1'b0;
        end else begin
            r_s3_vld  <= r_s2_vld;
            r_s3_acc  <= (r_s2_max | r_s2_min) & (r_s2_abs >= L_TH) & ~r_s2_border;
            r_s3_max  <= r_s2_max;
            r_s3_c    <= r_s2_c;
            r_s3_x    <= r_s2_x;
            r_s3_y    <= r_s2_y;
            r_s3_last <= r_s2_last;
        end
    end

    assign frame_done = r_s3_vld & r_s3_last;

    // ---------------- keypoint FIFO ----------------
    logic [EW-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_cnt;
    logic          r_kp_ovf;
    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_wr;
    logic          w_drop;
    logic [AW-1:0] w_head;
    logic [EW-1:0] w_push_data;

    assign w_empty     = (r_cnt == '0);
    assign w_full      = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_push      = r_s3_vld & r_s3_acc;
    assign w_pop       = kp_valid & kp_ready;
    assign w_wr        = w_push & (~w_full | w_pop);
    assign w_drop      = w_push & w_full & ~w_pop;
    assign w_push_data = {r_s3_x, r_s3_y, r_s3_max, r_s3_c};

    // When empty, point at the last popped slot so kp_* keep their previous values;
    // the next write lands on r_rd_ptr, so that slot is not overwritten while empty.
    assign w_head = w_empty ? (r_rd_ptr - AW'(1)) : r_rd_ptr;

    assign kp_valid                   = ~w_empty;
    assign {kp_x, kp_y, kp_max, kp_val} = r_mem[w_head];
    assign kp_ovf                     = r_kp_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            r_kp_ovf <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wr_ptr] <= w_push_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_cnt    <= r_cnt + (AW+1)'(w_wr) - (AW+1)'(w_pop);
            r_kp_ovf <= r_kp_ovf | w_drop;
        end
    end

`ifdef EXTREMA_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_dog_extrema_detect.sv
// Directed and randomized checks of dog_extrema_detect against a window-level reference model.
module tb_dog_extrema_detect;
    localparam int DW    = 8;
    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int XW    = 4;
    localparam int YW    = 3;
    localparam int TH    = 3;
    localparam int DEPTH = 4;
    localparam int NPIX  = IMG_W * IMG_H;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             win_en = 1'b0;
    logic [27*DW-1:0] win = '0;
    logic             kp_ready = 1'b1;
    logic             kp_valid;
    logic [XW-1:0]    kp_x;
    logic [YW-1:0]    kp_y;
    logic             kp_max;
    logic [DW-1:0]    kp_val;
    logic             kp_ovf;
    logic             frame_done;
`ifdef EXTREMA_DROP_CNT_EN
    logic [15:0]      drop_cnt;
`endif

    dog_extrema_detect #(
        .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .XW(XW), .YW(YW),
        .CONTRAST_TH(TH), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .win_en(win_en), .win(win),
        .kp_valid(kp_valid), .kp_ready(kp_ready), .kp_x(kp_x), .kp_y(kp_y),
        .kp_max(kp_max), .kp_val(kp_val), .kp_ovf(kp_ovf), .frame_done(frame_done)
`ifdef EXTREMA_DROP_CNT_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int            x;
        int            y;
        bit            mx;
        logic [DW-1:0] val;
    } kp_t;

    kp_t exp_q[$];
    int  n_tests = 0;
    int  n_fail = 0;
    int  n_win = 0;
    int  fd_exp = 0;
    int  fd_seen = 0;
    int  drops_exp = 0;
    bit  model_cap = 1'b0;
    int  nb[26];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference: decide the window from its values and its ordinal within the frame, then drive it.
    task automatic send(input int c);
        int  pos, x, y, a, v;
        bit  mx, mn, border;
        kp_t e;
        pos = n_win % NPIX;
        x = pos % IMG_W;
        y = pos / IMG_W;
        mx = 1'b1;
        mn = 1'b1;
        foreach (nb[i]) begin
            if (!(c > nb[i])) mx = 1'b0;
            if (!(c < nb[i])) mn = 1'b0;
        end
        a = (c < 0) ? -c : c;
        border = (x == 0) || (x == IMG_W-1) || (y == 0) || (y == IMG_H-1);
        if ((mx || mn) && a >= TH && !border) begin
            if (model_cap && exp_q.size() >= DEPTH) begin
                drops_exp++;
            end else begin
                e.x = x; e.y = y; e.mx = mx; e.val = c[DW-1:0];
                exp_q.push_back(e);
            end
        end
        if (pos == NPIX-1) fd_exp++;
        n_win++;
        for (int k = 0; k < 27; k++) begin
            v = (k == 13) ? c : nb[(k < 13) ? k : k-1];
            win[k*DW +: DW] = v[DW-1:0];
        end
        win_en = 1'b1;
        @(posedge clk); #1;
        win_en = 1'b0;
    endtask

    task automatic set_flat(input int v);
        foreach (nb[i]) nb[i] = v;
    endtask

    task automatic advance_to(input int target);
        while (n_win < target) begin
            set_flat(0);
            send(0);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && (exp_q.size() != 0 || kp_valid); i++) begin
            @(posedge clk); #1;
        end
        check(tag, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every popped head must be the oldest expected keypoint; a stalled head must not move.
    logic [XW+YW+DW:0] hold_vec;
    bit                hold_vld = 1'b0;

    always @(negedge clk) begin
        kp_t e;
        if (rst) begin
            hold_vld = 1'b0;
        end else begin
            if (frame_done) fd_seen++;
            if (kp_valid) begin
                if (hold_vld) check("hold_stable", 32'({kp_x, kp_y, kp_max, kp_val}), 32'(hold_vec));
                check("kp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (kp_ready && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("kp_x", 32'(kp_x), 32'(e.x));
                    check("kp_y", 32'(kp_y), 32'(e.y));
                    check("kp_max", 32'(kp_max), 32'(e.mx));
                    check("kp_val", 32'(kp_val), 32'(e.val));
                end
                hold_vld = !kp_ready;
                hold_vec = {kp_x, kp_y, kp_max, kp_val};
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int c, mode;

        // reset state
        idle(3);
        check("rst_kp_valid", 32'(kp_valid), 32'd0);
        check("rst_kp_ovf", 32'(kp_ovf), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_kp_data", 32'({kp_x, kp_y, kp_max, kp_val}), 32'd0);
`ifdef EXTREMA_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        rst = 1'b0;
        idle(2);

        // frame A: border extrema rejected, interior max/min/tie/contrast cases
        advance_to(3);                      // (3,0)
        set_flat(10); send(50);
        advance_to(16);                     // (0,2)
        set_flat(10); send(50);
        advance_to(19);                     // (3,2): timed max keypoint
        set_flat(10); send(50);
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (kp_valid && lat == 0) lat = i;
        end
        check("latency", 32'(lat), 32'd4);
        @(posedge clk); #1;
        set_flat(0); send(-40);             // (4,2) min
        set_flat(10); nb[7] = 50; send(50); // (5,2) tie -> none
        advance_to(23);                     // (7,2)
        set_flat(10); send(50);
        advance_to(25);
        set_flat(0); send(2);               // (1,3) below contrast
        set_flat(0); send(3);               // (2,3) at contrast
        set_flat(0); send(-128);            // (3,3) magnitude 128
        advance_to(43);                     // (3,5)
        set_flat(10); send(50);
        advance_to(NPIX);
        idle(6);
        check("frame_done_once", 32'(fd_seen), 32'd1);
        drain("drain_frameA");

        // next frame starts at (0,0): interior point at ordinal 10 is (2,1)
        advance_to(NPIX + 10);
        set_flat(-5); send(20);
        drain("drain_wrap");

        // overflow: 6 accepted with downstream stalled
        check("ovf_before", 32'(kp_ovf), 32'd0);
        advance_to(NPIX + 17);
        kp_ready = 1'b0;
        model_cap = 1'b1;
        for (int i = 0; i < 6; i++) begin
            set_flat(0); send(10 + i);
        end
        idle(5);
        check("ovf_kp_valid", 32'(kp_valid), 32'd1);
        check("ovf_sticky", 32'(kp_ovf), 32'd1);
`ifdef EXTREMA_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(drops_exp));
`endif
        model_cap = 1'b0;
        kp_ready = 1'b1;
        drain("drain_ovf");

        // full FIFO with push and pop on the same edge
        advance_to(NPIX + 25);
        kp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_flat(-20); send(-30 - i);
        end
        @(posedge clk); @(posedge clk); #1;
        kp_ready = 1'b1;
        drain("drain_full_pushpop");
        check("ovf_still_set", 32'(kp_ovf), 32'd1);
`ifdef EXTREMA_DROP_CNT_EN
        check("drop_cnt_no_new", 32'(drop_cnt), 32'(drops_exp));
`endif

        // reset with 2 queued and 3 in flight
        advance_to(NPIX + 33);
        kp_ready = 1'b0;
        set_flat(0); send(40);
        set_flat(0); send(41);
        idle(5);
        for (int i = 0; i < 3; i++) begin
            set_flat(0); send(60 + i);
        end
        rst = 1'b1;
        exp_q.delete();
        n_win = 0;
        drops_exp = 0;
        @(negedge clk);
        check("rst_mid_kp_valid", 32'(kp_valid), 32'd0);
        check("rst_mid_kp_ovf", 32'(kp_ovf), 32'd0);
`ifdef EXTREMA_DROP_CNT_EN
        check("rst_mid_drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;
        kp_ready = 1'b1;
        idle(10);
        check("no_stale_kp", 32'(kp_valid), 32'd0);
        advance_to(9);                      // (1,1) after reset
        set_flat(10); send(50);
        drain("drain_after_rst");

        // randomized windows
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                c = int'($urandom_range(0, 255)) - 128;
                mode = int'($urandom_range(0, 3));
                for (int j = 0; j < 26; j++) begin
                    if (mode == 0)
                        nb[j] = (c == -128) ? 0 : c - 1 - int'($urandom_range(0, c + 127));
                    else if (mode == 1)
                        nb[j] = (c == 127) ? 0 : c + 1 + int'($urandom_range(0, 126 - c));
                    else
                        nb[j] = int'($urandom_range(0, 255)) - 128;
                end
                if (mode == 3) nb[$urandom_range(0, 25)] = c;
                send(c);
            end else begin
                idle(1);
            end
        end
        idle(6);
        drain("drain_random");
        check("frame_done_total", 32'(fd_seen), 32'(fd_exp));
        check("ovf_final", 32'(kp_ovf), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
